jb_xssi_accum: RTL
==================

Name: jb_xssi_accum

Overview:
- RSSI/XSSI power accumulator in the 15.36 MHz domain. Sits directly downstream of the XSSI window counter and consumes its rssi_load pulse.
- Computes instantaneous power I^2+Q^2 per valid IQ sample and sums it over the window.
- On each window boundary, publishes the summed power, the sample count and a saturation flag, then restarts accumulation from zero.

Parameters:
- DATA_W, 16, signed width of i_data/q_data
- ACC_W, 48, accumulator/result width (must be >= 2*DATA_W)
- CNT_W, 21, sample-count width (matches the window tic counter width)

Ports:
- clk_15p36  in  1  15.36 MHz clock
- resetn_15p36  in  1  reset; asynchronous, active-low
- win_enable  in  1  high when the window count is non-zero; low = block idle
- rssi_load  in  1  one-cycle window-end pulse from the window counter
- iq_valid  in  1  IQ sample qualifier
- i_data  in  DATA_W  signed I sample
- q_data  in  DATA_W  signed Q sample
- xssi_power  out  ACC_W  summed power of the last completed window
- xssi_sample_cnt  out  CNT_W  number of valid samples in that window
- xssi_sat  out  1  accumulator or count saturated during that window
- xssi_valid  out  1  one-cycle pulse: the result outputs were updated

Behaviour:
- Reset (async assert, sync deassert handled upstream): all pipeline regs, accumulator, count, sat flag and all outputs = 0.
- Stage 1 (S1): register i_data^2, q_data^2 (each 2*DATA_W unsigned) and iq_valid.
- Stage 2 (S2): register p = i^2+q^2, width 2*DATA_W unsigned.
  - Maximum p = 2^(2*DATA_W-1), at i=q=-2^(DATA_W-1), so no overflow.
  - Register p_vld alongside p.
- rssi_load is delayed two cycles (load_d2) to align with S2. An IQ sample presented in the same cycle as rssi_load belongs to the closing window.
- Accumulate stage, on a cycle without load_d2:
  - if p_vld: acc += p, saturating at 2^ACC_W-1; saturation sets sat_win.
  - if p_vld: cnt += 1, saturating at 2^CNT_W-1; saturation sets sat_win.
- Accumulate stage, on a cycle with load_d2:
  - xssi_power <= acc + (p_vld ? p : 0), saturated.
  - xssi_sample_cnt <= cnt + p_vld, saturated.
  - xssi_sat <= sat_win OR saturation in this cycle.
  - xssi_valid <= 1.
  - acc, cnt and sat_win are cleared to 0. The p in this cycle is NOT carried into the new window.
- Latency: rssi_load high in cycle t gives xssi_valid high in cycle t+3. xssi_valid is high for exactly one cycle per load.
- Result outputs hold their value between pulses.
- Back-to-back loads (window length 1) are legal and give one result per cycle.
- win_enable low:
  - acc, cnt, sat_win, load delay line and S1/S2 valid bits are cleared.
  - rssi_load is ignored and xssi_valid = 0.
  - Result outputs hold their last value.
- win_enable rising: accumulation starts fresh. The first result covers only samples after re-enable.
- Load with no valid samples in the window: power=0, cnt=0, sat=0, valid pulse still produced.
- All arithmetic is unsigned after squaring. Operands are zero-extended to ACC_W before the add.

Optional Feature:
- Macro: JB_XSSI_PEAK_EN
- Defined:
  - Adds output xssi_peak (2*DATA_W), the maximum single-sample p in the window.
  - Tracked at the accumulate stage. On load_d2, xssi_peak <= max(peak_win, p_vld ? p : 0) and peak_win is cleared.
  - Reset value 0; cleared with win_enable low like acc. Updated only with xssi_valid.
- Undefined: port and logic absent. All other behaviour is identical.

Test Plan:
- Defaults; i=3, q=4, iq_valid=1 continuously; rssi_load every 10 cycles -> xssi_power=250, xssi_sample_cnt=10, xssi_sat=0; xssi_valid exactly 3 cycles after each load, once per load.
- ACC_W=34; i=q=-32768 every cycle; load every 8 cycles -> p=2^31, sum 2^34 exceeds the limit -> xssi_power=2^34-1, xssi_sat=1. Next window with i=q=0 -> power=0, sat=0.
- iq_valid=0 for an entire 5-cycle window -> xssi_power=0, xssi_sample_cnt=0, valid pulse at load+3.
- rssi_load high every cycle, i=1, q=2, valid every cycle -> xssi_valid every cycle, each xssi_power=5, cnt=1. A sample coincident with a load is counted in the closing window only.
- win_enable dropped mid-window for 4 cycles with a load pulse inside, then restored -> no xssi_valid during the gap; first post-gap result counts only post-gap samples. Same check for resetn_15p36 asserted mid-window: all outputs 0 immediately (async).
- JB_XSSI_PEAK_EN defined; samples (1,1), (10,0), (2,2) then load -> xssi_power=110, xssi_peak=100, cnt=3.

Source files
------------

// File: rtl/jb_xssi_accum.sv
// jb_xssi_accum: sums I^2+Q^2 over each XSSI window and publishes power, sample count and saturation.
// Optional macro JB_XSSI_PEAK_EN adds xssi_peak, the largest single-sample power seen in the window.
module jb_xssi_accum #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 48,
    parameter int CNT_W  = 21
) (
    input  logic                     clk_15p36,
    input  logic                     resetn_15p36,
    input  logic                     win_enable,
    input  logic                     rssi_load,
    input  logic                     iq_valid,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic signed [DATA_W-1:0] q_data,
    output logic [ACC_W-1:0]         xssi_power,
    output logic [CNT_W-1:0]         xssi_sample_cnt,
    output logic                     xssi_sat,
`ifdef JB_XSSI_PEAK_EN
    output logic [2*DATA_W-1:0]      xssi_peak,
`endif
    output logic                     xssi_valid
);

    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] iExt, qExt;
    logic [PW-1:0]        iSq_d, iSq_q, qSq_d, qSq_q, p_d, p_q, pAdd;
    logic                 s1Vld_d, s1Vld_q, pVld_d, pVld_q;
    logic                 load1_d, load1_q, load2_d, load2_q;
    logic [ACC_W:0]       accSum;
    logic [CNT_W:0]       cntSum;
    logic                 accOvf, cntOvf;
    logic [ACC_W-1:0]     accNext, acc_d, acc_q, power_d, power_q;
    logic [CNT_W-1:0]     cntNext, cnt_d, cnt_q, cntOut_d, cntOut_q;
    logic                 satWin_d, satWin_q, sat_d, sat_q, valid_d, valid_q;

    assign iExt = PW'(i_data);
    assign qExt = PW'(q_data);

    // Dropping win_enable squashes every in-flight sample and load so the next window starts clean.
    always_comb begin
        iSq_d    = iExt * iExt;
        qSq_d    = qExt * qExt;
        p_d      = iSq_q + qSq_q;
        s1Vld_d  = iq_valid & win_enable;
        pVld_d   = s1Vld_q & win_enable;
        load1_d  = rssi_load & win_enable;
        load2_d  = load1_q & win_enable;

        pAdd     = pVld_q ? p_q : '0;
        accSum   = {1'b0, acc_q} + (ACC_W+1)'(pAdd);
        accOvf   = accSum[ACC_W];
        accNext  = accOvf ? '1 : accSum[ACC_W-1:0];
        cntSum   = {1'b0, cnt_q} + (CNT_W+1)'(pVld_q);
        cntOvf   = cntSum[CNT_W];
        cntNext  = cntOvf ? '1 : cntSum[CNT_W-1:0];

        acc_d    = accNext;
        cnt_d    = cntNext;
        satWin_d = satWin_q | accOvf | cntOvf;
        power_d  = power_q;
        cntOut_d = cntOut_q;
        sat_d    = sat_q;
        valid_d  = 1'b0;

        if (!win_enable) begin
            acc_d    = '0;
            cnt_d    = '0;
            satWin_d = 1'b0;
        end else if (load2_q) begin
            power_d  = accNext;
            cntOut_d = cntNext;
            sat_d    = satWin_q | accOvf | cntOvf;
            valid_d  = 1'b1;
            acc_d    = '0;
            cnt_d    = '0;
            satWin_d = 1'b0;
        end
    end

    always_ff @(posedge clk_15p36 or negedge resetn_15p36) begin
        if (!resetn_15p36) begin
            iSq_q    <= '0;
            qSq_q    <= '0;
            p_q      <= '0;
            s1Vld_q  <= 1'b0;
            pVld_q   <= 1'b0;
            load1_q  <= 1'b0;
            load2_q  <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
            satWin_q <= 1'b0;
            power_q  <= '0;
            cntOut_q <= '0;
            sat_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            iSq_q    <= iSq_d;
            qSq_q    <= qSq_d;
            p_q      <= p_d;
            s1Vld_q  <= s1Vld_d;
            pVld_q   <= pVld_d;
            load1_q  <= load1_d;
            load2_q  <= load2_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            satWin_q <= satWin_d;
            power_q  <= power_d;
            cntOut_q <= cntOut_d;
            sat_q    <= sat_d;
            valid_q  <= valid_d;
        end
    end

    assign xssi_power      = power_q;
    assign xssi_sample_cnt = cntOut_q;
    assign xssi_sat        = sat_q;
    assign xssi_valid      = valid_q;

`ifdef JB_XSSI_PEAK_EN
    logic [PW-1:0] peakNext, peakWin_d, peakWin_q, peakOut_d, peakOut_q;

    always_comb begin
        peakNext  = (pAdd > peakWin_q) ? pAdd : peakWin_q;
        peakWin_d = peakNext;
        peakOut_d = peakOut_q;
        if (!win_enable) begin
            peakWin_d = '0;
        end else if (load2_q) begin
            peakOut_d = peakNext;
            peakWin_d = '0;
        end
    end

    always_ff @(posedge clk_15p36 or negedge resetn_15p36) begin
        if (!resetn_15p36) begin
            peakWin_q <= '0;
            peakOut_q <= '0;
        end else begin
            peakWin_q <= peakWin_d;
            peakOut_q <= peakOut_d;
        end
    end

    assign xssi_peak = peakOut_q;
`endif

endmodule
